// File: rtl/srgate_pkg.sv
// Shared types and helpers for the multi-channel set/reset gate.
// Edge-select encodings and the edge detector used by every channel.
package srgate_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE  = 2'd0,
    EDGE_FALL  = 2'd1,
    EDGE_BOTH  = 2'd2,
    EDGE_RISE3 = 2'd3
  } edge_sel_e;

  function automatic logic edge_detect(
    input logic       cur,
    input logic       prev,
    input logic [1:0] sel
  );
    logic rise;
    logic fall;
    logic hit;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_sel_e'(sel))
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = rise;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/srgate_chan.sv
// One set/reset gate channel: edge detect, priority resolve,
// and an optional retriggerable auto-reset counter.
module srgate_chan
  import srgate_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             set_i,
  input  logic             rst_i,
  input  logic [1:0]       set_edge,
  input  logic [1:0]       rst_edge,
  input  logic             rst_prio,
  input  logic             force_set,
  input  logic             force_rst,
  input  logic [CNT_W-1:0] timeout,
  output logic             out_o
);

  logic             set_q;
  logic             rst_q;
  logic             out_q;
  logic             out_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             set_ev;
  logic             rst_ev;
  logic             to_ev;
  logic             load;

  assign set_ev = edge_detect(set_i, set_q, set_edge);
  assign rst_ev = edge_detect(rst_i, rst_q, rst_edge);
  assign to_ev  = (timeout != '0) && out_q
               && (cnt_q == CNT_W'(1));

  always_comb begin
    out_d = out_q;
    load  = 1'b0;
    if (force_rst) begin
      out_d = 1'b0;
    end else if (force_set) begin
      out_d = 1'b1;
      load  = 1'b1;
    end else if (set_ev && rst_ev) begin
      out_d = ~rst_prio;
      load  = ~rst_prio;
    end else if (set_ev) begin
      out_d = 1'b1;
      load  = 1'b1;
    end else if (rst_ev || to_ev) begin
      out_d = 1'b0;
    end
  end

  // Counter parks at 1 until expiry; with timeout 0 it stays idle at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!out_d) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = timeout;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      set_q <= 1'b0;
      rst_q <= 1'b0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      set_q <= set_i;
      rst_q <= rst_i;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/srgate_array.sv
// NUM_CH independent set/reset gates sharing one TIMEOUT register.
// Slices the per-channel register buses onto srgate_chan copies.
module srgate_array
  import srgate_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [NUM_CH-1:0]   set_i,
  input  logic [NUM_CH-1:0]   rst_i,
  input  logic [2*NUM_CH-1:0] SET_EDGE,
  input  logic [2*NUM_CH-1:0] RST_EDGE,
  input  logic [NUM_CH-1:0]   RST_PRIO,
  input  logic [NUM_CH-1:0]   FORCE_SET,
  input  logic [NUM_CH-1:0]   FORCE_RST,
  input  logic [CNT_W-1:0]    TIMEOUT,
  output logic [NUM_CH-1:0]   out_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    srgate_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .set_i     (set_i[c]),
      .rst_i     (rst_i[c]),
      .set_edge  (SET_EDGE[2*c +: 2]),
      .rst_edge  (RST_EDGE[2*c +: 2]),
      .rst_prio  (RST_PRIO[c]),
      .force_set (FORCE_SET[c]),
      .force_rst (FORCE_RST[c]),
      .timeout   (TIMEOUT),
      .out_o     (out_o[c])
    );
  end

endmodule

// File: doc/srgate_array.md
# srgate_array

Parametrised, multi-channel successor to the single set/reset gate. Each of NUM_CH channels latches a registered output high on a selectable edge of its set input and low on a selectable edge of its reset input. Compared with the single gate it adds:

- a per-channel set/reset priority bit,
- single-cycle force strobes,
- an optional auto-reset timeout that turns the gate into a retriggerable pulse generator.

It sits on the position/bit bus between block inputs and downstream logic, with its registers driven from the block register interface.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- CNT_W, 32, width of the timeout counter and the TIMEOUT register.

Ports:
- clk_i  in  1  system clock; all logic is on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- set_i  in  NUM_CH  per-channel set inputs; synchronous to clk_i.
- rst_i  in  NUM_CH  per-channel reset inputs; synchronous to clk_i.
- SET_EDGE  in  2*NUM_CH  per-channel set edge select, bits [2c+1:2c]: 0 rising, 1 falling, 2 either, 3 rising.
- RST_EDGE  in  2*NUM_CH  per-channel reset edge select; same encoding as SET_EDGE.
- RST_PRIO  in  NUM_CH  per channel, when set and reset events coincide: 1 reset wins, 0 set wins.
- FORCE_SET  in  NUM_CH  per-channel single-cycle write strobe that sets the output.
- FORCE_RST  in  NUM_CH  per-channel single-cycle write strobe that clears the output.
- TIMEOUT  in  CNT_W  auto-reset length in cycles, shared by all channels; 0 disables auto-reset.
- out_o  out  NUM_CH  registered gate outputs.

## Operation
Per channel c:
- Previous-value registers hold set_i and rst_i from the last cycle. Edge detection is combinational against these registers:
  - set_ev = selected edge of set_i.
  - rst_ev = selected edge of rst_i.
- Changing SET_EDGE or RST_EDGE never produces an event by itself.
- To_ev = auto-reset expiry: TIMEOUT≠0, out high, and counter==1.
- Next-state priority, highest first:
  1. FORCE_RST.
  2. FORCE_SET.
  3. Coincident set_ev and rst_ev: resolved by RST_PRIO.
  4. A single set_ev or rst_ev.
  5. To_ev (clears out).
  6. Otherwise hold.
- A set_ev, FORCE_SET, or set-winning coincidence while the output is already high retriggers the counter. A set_ev that loses to rst_ev does not.
- FORCE_SET and FORCE_RST in the same cycle clear the output.
- Counter behaviour:
  - Loaded with TIMEOUT whenever the output is set or retriggered.
  - Decrements each cycle while out is high and the counter is >1.
  - Cleared when out clears.
- TIMEOUT changes take effect on the next load only; a running pulse keeps its length.
- TIMEOUT=0 gives pure SR latch behaviour and the counter is idle.
- Channels are fully independent; there is no cross-channel interaction.

## Timing
- Reset: out_o=0, all previous-value registers=0, all counters=0.
- Because the previous registers reset to 0, an input already high at the first clock after reset release is a rising edge.
- Latency: an input sampled on clock edge k with a qualifying edge updates out_o at edge k. Out is therefore visible one cycle after the input changed.
- Force strobes: a strobe high during cycle k updates out_o at the end of cycle k.
- Auto-reset: out_o is high for exactly TIMEOUT cycles after the edge that set it. Example: TIMEOUT=1 gives a one-cycle pulse.
- To_ev and set_ev in the same cycle: set wins and the counter reloads, so there is no gap in out_o.
- To_ev and rst_ev in the same cycle: out clears; the result is identical either way.
- Counter never wraps. It saturates at 1 when reached and then expires.
- Asserting reset_n_i mid-pulse clears out_o and the counter immediately, without waiting for a clock. Operation resumes from the reset state.

## Structure
- Package srgate_pkg holds:
  - edge-select encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2;
  - function edge_detect(cur, prev, sel).
- Sub-module srgate_chan implements one channel: previous registers, priority logic and counter, parameter CNT_W.
- srgate_array instantiates NUM_CH copies of srgate_chan in a generate loop and slices the register buses.
- Expected size is roughly 200 RTL lines in total.

## Test plan
- **Edge select:** ch0, SET_EDGE=0, RST_EDGE=1, TIMEOUT=0; pulse set_i high on cycle 10 and rst_i high on cycles 20–24 -> out_o[0] rises at edge 10 and falls at edge 25.
- **Coincidence priority:** set_i and rst_i rise together on cycle 30 with RST_PRIO=1 -> out stays 0. Repeat with RST_PRIO=0 -> out=1 from edge 30.
- **Force strobes:** FORCE_SET strobe alone -> out=1 next edge. Then FORCE_SET and FORCE_RST strobed together -> out=0. FORCE_RST during a set edge -> out=0.
- **Auto-reset and retrigger:** TIMEOUT=5 with a set rising edge at cycle 40 -> out high for cycles 40–44. A second set edge at cycle 43 -> out stays high until cycle 47. An expiry-cycle set edge gives a continuous high output.
- **Channel independence and reset:** NUM_CH=4 with different edge modes on each channel, driven by random stimulus and checked against a reference model. Assert reset_n_i mid-pulse on ch2 -> all out_o=0 asynchronously. Set_i held high through reset release -> rising edge on the first clock.
